// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: ALU/load write-back arbiter with pending-write scoreboard.
// Define REGARB_FIXED_PRIO_EN to give the load requester fixed priority.
module regfile_wr_arbiter #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int CNT_W    = 2
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                req0_valid,
  input  logic [2:0]          req0_dr,
  input  logic [DATA_W-1:0]   req0_data,
  output logic                req0_ready,
  input  logic                req1_valid,
  input  logic [2:0]          req1_dr,
  input  logic [DATA_W-1:0]   req1_data,
  output logic                req1_ready,
  input  logic                issue_valid,
  input  logic [2:0]          issue_dr,
  output logic                issue_ready,
  output logic                wr_en,
  output logic [2:0]          wr_dr,
  output logic [DATA_W-1:0]   wr_data,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic                last_grant
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic                w_gnt0;
  logic                w_gnt1;
  logic                r_wr_en;
  logic [2:0]          r_wr_dr;
  logic [DATA_W-1:0]   r_wr_data;
  logic                r_last;
  logic [CNT_W-1:0]    r_cnt [NUM_REGS];
  logic [NUM_REGS-1:0] w_inc;
  logic [NUM_REGS-1:0] w_dec;

`ifdef REGARB_FIXED_PRIO_EN
  always_comb begin
    w_gnt1 = req1_valid;
    w_gnt0 = req0_valid & ~req1_valid;
  end
`else
  typedef enum logic {PREF0, PREF1} state_t;
  state_t r_state;
  state_t w_state_nxt;

  always_ff @(posedge Clk) begin
    if (Reset) r_state <= PREF0;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    w_state_nxt = r_state;
    unique case (r_state)
      PREF0: begin
        w_gnt0 = req0_valid;
        w_gnt1 = req1_valid & ~req0_valid;
      end
      PREF1: begin
        w_gnt1 = req1_valid;
        w_gnt0 = req0_valid & ~req1_valid;
      end
    endcase
    if (w_gnt0)      w_state_nxt = PREF1;
    else if (w_gnt1) w_state_nxt = PREF0;
  end
`endif

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_wr_en   <= 1'b0;
      r_wr_dr   <= '0;
      r_wr_data <= '0;
      r_last    <= 1'b0;
    end else begin
      r_wr_en <= w_gnt0 | w_gnt1;
      if (w_gnt0) begin
        r_wr_dr   <= req0_dr;
        r_wr_data <= req0_data;
        r_last    <= 1'b0;
      end else if (w_gnt1) begin
        r_wr_dr   <= req1_dr;
        r_wr_data <= req1_data;
        r_last    <= 1'b1;
      end
    end
  end

  assign wr_en      = r_wr_en;
  assign wr_dr      = r_wr_dr;
  assign wr_data    = r_wr_data;
  assign last_grant = r_last;

  assign issue_ready = (r_cnt[issue_dr] != CNT_MAX);

  always_comb begin
    w_inc = '0;
    w_dec = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_inc[i] = issue_valid & issue_ready & (issue_dr == 3'(i));
      w_dec[i] = r_wr_en & (r_wr_dr == 3'(i));
    end
  end

  // Simultaneous issue and commit on one register cancel out.
  always_ff @(posedge Clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (Reset)
        r_cnt[i] <= '0;
      else if (w_inc[i] && !w_dec[i])
        r_cnt[i] <= r_cnt[i] + CNT_W'(1);
      else if (w_dec[i] && !w_inc[i] && r_cnt[i] != '0)
        r_cnt[i] <= r_cnt[i] - CNT_W'(1);
    end
  end

  always_comb begin
    busy_vec = '0;
    for (int i = 0; i < NUM_REGS; i++)
      busy_vec[i] = (r_cnt[i] != '0);
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb_regfile_wr_arbiter: directed plus random stimulus, scoreboard on the write port.
// Reference model tracks preference, last grant and pending counts per register.
module tb_regfile_wr_arbiter;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        req0_valid = 1'b0;
  logic [2:0]  req0_dr = '0;
  logic [15:0] req0_data = '0;
  logic        req0_ready;
  logic        req1_valid = 1'b0;
  logic [2:0]  req1_dr = '0;
  logic [15:0] req1_data = '0;
  logic        req1_ready;
  logic        issue_valid = 1'b0;
  logic [2:0]  issue_dr = '0;
  logic        issue_ready;
  logic        wr_en;
  logic [2:0]  wr_dr;
  logic [15:0] wr_data;
  logic [7:0]  busy_vec;
  logic        last_grant;

  regfile_wr_arbiter dut (
    .Clk(Clk), .Reset(Reset),
    .req0_valid(req0_valid), .req0_dr(req0_dr),
    .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_dr(req1_dr),
    .req1_data(req1_data), .req1_ready(req1_ready),
    .issue_valid(issue_valid), .issue_dr(issue_dr),
    .issue_ready(issue_ready),
    .wr_en(wr_en), .wr_dr(wr_dr), .wr_data(wr_data),
    .busy_vec(busy_vec), .last_grant(last_grant)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int dr;
    int data;
    int due;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  int   m_pref = 0;
  int   m_last = 0;
  int   mcnt[8];
  bit   m_wv = 0;
  int   m_wdr = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge Clk);
    #1;
    if (wr_en === 1'b1) begin
      if (q.size() == 0) begin
        check("wr_unexpected", 32'(wr_en), 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("wr_due", 32'(cyc), 32'(e.due));
        check("wr_dr", 32'(wr_dr), 32'(e.dr));
        check("wr_data", 32'(wr_data), 32'(e.data));
      end
    end else begin
      check("wr_en_x", 32'(wr_en), 32'd0);
      if (q.size() > 0 && q[0].due <= cyc) begin
        void'(q.pop_front());
        check("wr_missing", 32'(wr_en), 32'd1);
      end
    end
  end

  task automatic step(input bit v0, input int dr0, input int d0,
                      input bit v1, input int dr1, input int d1,
                      input bit iv, input int idr, input bit rst,
                      output bit g0, output bit g1);
    bit inc;
    @(negedge Clk);
    Reset       = rst;
    req0_valid  = v0;
    req0_dr     = 3'(dr0);
    req0_data   = 16'(d0);
    req1_valid  = v1;
    req1_dr     = 3'(dr1);
    req1_data   = 16'(d1);
    issue_valid = iv;
    issue_dr    = 3'(idr);
    #1;
`ifdef REGARB_FIXED_PRIO_EN
    g1 = v1;
    g0 = v0 && !v1;
`else
    if (v0 && v1) begin
      g0 = (m_pref == 0);
      g1 = (m_pref == 1);
    end else begin
      g0 = v0;
      g1 = v1;
    end
`endif
    check("req0_ready", 32'(req0_ready), 32'(g0));
    check("req1_ready", 32'(req1_ready), 32'(g1));
    check("issue_ready", 32'(issue_ready), 32'(mcnt[idr] != 3));
    for (int i = 0; i < 8; i++)
      check($sformatf("busy_vec[%0d]", i), 32'(busy_vec[i]),
            32'(mcnt[i] != 0));
    check("last_grant", 32'(last_grant), 32'(m_last));
    if (rst) begin
      foreach (mcnt[i]) mcnt[i] = 0;
      m_wv   = 0;
      m_pref = 0;
      m_last = 0;
      g0 = 0;
      g1 = 0;
    end else begin
      inc = iv && (mcnt[idr] != 3);
      if (!(inc && m_wv && idr == m_wdr)) begin
        if (inc) mcnt[idr]++;
        if (m_wv && mcnt[m_wdr] > 0) mcnt[m_wdr]--;
      end
      m_wv = g0 || g1;
      if (g0) begin
        q.push_back('{dr: dr0, data: d0 & 'hffff, due: cyc + 1});
        m_wdr = dr0; m_pref = 1; m_last = 0;
      end else if (g1) begin
        q.push_back('{dr: dr1, data: d1 & 'hffff, due: cyc + 1});
        m_wdr = dr1; m_pref = 0; m_last = 1;
      end
    end
  endtask

  task automatic idle(input int n);
    bit a, b;
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, a, b);
  endtask

  task automatic issue(input int dr);
    bit a, b;
    step(0, 0, 0, 0, 0, 0, 1, dr, 0, a, b);
  endtask

  initial begin
    bit g0, g1;
    bit p0, p1;
    int pdr0, pd0, pdr1, pd1;
    foreach (mcnt[i]) mcnt[i] = 0;
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, g0, g1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, g0, g1);
    idle(1);
    step(1, 3, 'h1234, 0, 0, 0, 0, 0, 0, g0, g1);
    idle(2);
    for (int i = 0; i < 4; i++)
      step(1, 1, 'hAAAA, 1, 2, 'h5555, 0, 0, 0, g0, g1);
    idle(2);
    repeat (3) issue(7);
    issue(7);
    step(0, 0, 0, 1, 7, 'h0777, 0, 7, 0, g0, g1);
    idle(2);
    issue(4);
    step(1, 4, 'h0444, 0, 0, 0, 0, 0, 0, g0, g1);
    issue(4);
    idle(2);
    step(1, 5, 'h0555, 0, 0, 0, 0, 0, 0, g0, g1);
    idle(2);
    issue(2);
    step(0, 0, 0, 1, 6, 'h0666, 0, 0, 0, g0, g1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, g0, g1);
    idle(2);
    p0 = 0;
    p1 = 0;
    for (int n = 0; n < 400; n++) begin
      if (!p0) begin
        p0 = ($urandom_range(1) == 1);
        pdr0 = $urandom_range(7);
        pd0 = $urandom_range(16'hffff);
      end
      if (!p1) begin
        p1 = ($urandom_range(3) != 0);
        pdr1 = $urandom_range(7);
        pd1 = $urandom_range(16'hffff);
      end
      step(p0, pdr0, pd0, p1, pdr1, pd1,
           $urandom_range(1) == 1, $urandom_range(7),
           $urandom_range(63) == 0, g0, g1);
      if (g0 || Reset) p0 = 0;
      if (g1 || Reset) p1 = 0;
    end
    idle(3);
    check("queue_empty", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
- Shares the single register-file write port (LD_REG / destination select / bus data) between two write-back requesters: req0 = ALU write-back, req1 = memory-load write-back.
- Round-robin arbitration with a valid/ready handshake on each requester.
- Registered write-port outputs.
- A per-register pending-write scoreboard so the decode/sequencer stage can stall on read-after-write hazards.

Parameters:
- DATA_W, 16, width of write data.
- NUM_REGS, 8, number of architectural registers (R0-R7).
- CNT_W, 2, width of each per-register pending counter (max outstanding = 2^CNT_W - 1 = 3).

Ports:
- Clk  in  1  clock.
- Reset  in  1  synchronous, active-high reset.
- req0_valid  in  1  ALU write-back request.
- req0_dr  in  3  destination register for req0.
- req0_data  in  DATA_W  write data for req0.
- req0_ready  out  1  req0 accepted this cycle (combinational grant).
- req1_valid  in  1  load write-back request.
- req1_dr  in  3  destination register for req1.
- req1_data  in  DATA_W  write data for req1.
- req1_ready  out  1  req1 accepted this cycle.
- issue_valid  in  1  sequencer issues an instruction that will write issue_dr.
- issue_dr  in  3  destination of the issued instruction.
- issue_ready  out  1  low when issue_dr's counter is saturated.
- wr_en  out  1  register-file load enable (to LD_REG).
- wr_dr  out  3  register-file destination select.
- wr_data  out  DATA_W  register-file write data (to bus).
- busy_vec  out  NUM_REGS  bit i = 1 while R[i] has a nonzero pending count.
- last_grant  out  1  ID of the most recently granted requester.

Behaviour:
- Clock and reset: Clk is the clock. Reset is synchronous, active-high.
- Reset values:
  - wr_en = 0, wr_dr = 0, wr_data = 0.
  - All pending counters = 0, so busy_vec = 0.
  - Round-robin state = PREF0, last_grant = 0.
- Arbitration FSM, two states (PREF0 / PREF1):
  - In PREF0, req0 wins a tie; in PREF1, req1 wins a tie.
  - A lone valid requester is always granted, whatever the state.
  - After a grant to req0 the next state is PREF1; after a grant to req1 it is PREF0.
  - With no grant the state holds.
- Handshake:
  - reqN_ready is asserted only in the cycle reqN is granted. At most one ready is high per cycle.
  - The transfer occurs when valid && ready.
  - A requester holds valid, dr and data stable until it sees ready.
- Write-port latency:
  - Accepted transfer at edge k gives wr_en = 1 with wr_dr/wr_data = the granted dr/data during cycle k+1.
  - wr_en = 0 in any cycle following a cycle with no transfer.
  - Back-to-back transfers give wr_en high on consecutive cycles.
- Scoreboard:
  - cnt[issue_dr] increments on issue_valid && issue_ready.
  - cnt[wr_dr] decrements on a cycle with wr_en = 1 (the commit).
  - Same register incremented and decremented in the same cycle: net unchanged.
  - issue_ready = (cnt[issue_dr] != 2^CNT_W - 1); it is combinational.
  - A decrement at 0 (commit without a prior issue) saturates at 0; never wraps.
  - busy_vec[i] = (cnt[i] != 0), registered with the counters.
- Reset mid-operation:
  - An in-flight registered write is dropped: wr_en = 0 in the cycle after Reset.
  - Counters clear. Requesters must re-present their requests.
- Arithmetic: the dr fields are full 3-bit selects, no wrap. All of R0-R7, including R7 (the JSR/TRAP link), are valid destinations.

Optional Feature:
- Macro: REGARB_FIXED_PRIO_EN.
- Defined:
  - req1 (load) has fixed priority over req0.
  - The FSM is removed and last_grant still reports the granted ID.
  - req0 can starve while req1 is continuously valid.
- Undefined: round-robin behaviour as specified above.

Test Plan:
1. Reset, then req0_valid = 1, dr = 3, data = 0x1234 alone -> req0_ready = 1 the same cycle; next cycle wr_en = 1, wr_dr = 3, wr_data = 0x1234; then wr_en = 0.
2. Both valid continuously (req0 dr = 1 / 0xAAAA, req1 dr = 2 / 0x5555), starting in PREF0 -> grants alternate 0,1,0,1; wr_data sequence 0xAAAA, 0x5555, 0xAAAA, 0x5555; one ready high per cycle. With REGARB_FIXED_PRIO_EN -> req1 granted every cycle.
3. Issue dr = 7 three times -> busy_vec = 0x80, and issue_ready drops to 0 for dr = 7 (count 3). Then a req1 write to dr = 7 -> the count returns to 2 the cycle after wr_en, and issue_ready = 1.
4. issue_valid (dr = 4) in the same cycle as a commit wr_en for dr = 4 with count 1 -> count stays 1, busy_vec[4] stays 1.
5. Commit to dr = 5 with count 0 -> count stays 0, busy_vec[5] = 0.
6. Accept a transfer, then assert Reset in the next cycle -> wr_en = 0 and busy_vec = 0 after the edge; FSM = PREF0.
